// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Sits below the last PE of a systolic column. Sums iTiles consecutive signed
//   partial sums into one result (K-dimension tiling). It then requantizes each
//   result to 16 bits: a rounding right shift, an optional ReLU and saturation.
//   Results are queued in a show-ahead FIFO with a valid/ready output.
//
// Ports
//   iCLK, iRSTn     clock, synchronous active-low reset
//   iStart          start a job (honoured only when idle)
//   iTiles          partial sums per result (0 behaves as 1), latched on start
//   iNumOut         results in the job, latched on start
//   iShift          rounding right-shift amount, latched on start
//   iReluEn         clamp negative results to 0, latched on start
//   iPsumValid      partial sum present on iPsum
//   iPsum           signed partial sum
//   oPsumReady      partial sum is consumed this cycle when valid
//   oValid, oData   FIFO head (oData is 0 when the FIFO is empty)
//   iReady          downstream pops the FIFO head
//   oBusy           job in progress (not idle)
//   oDone           one-cycle pulse when the job has fully drained
//   oOverflow       sticky: some result saturated since the last start
module psum_accumulator #(
    parameter int unsigned IN_BW  = 35,
    parameter int unsigned ACC_BW = 43,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iStart,
    input  logic [7:0]       iTiles,
    input  logic [15:0]      iNumOut,
    input  logic [4:0]       iShift,
    input  logic             iReluEn,
    input  logic             iPsumValid,
    input  logic [IN_BW-1:0] iPsum,
    output logic             oPsumReady,
    output logic             oValid,
    output logic [15:0]      oData,
    input  logic             iReady,
    output logic             oBusy,
    output logic             oDone,
    output logic             oOverflow
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    // One extra bit so the rounding add cannot wrap.
    localparam int unsigned PpW  = ACC_BW + 1;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e            state_q;
    logic [7:0]        tiles_q;
    logic [7:0]        tile_cnt_q;
    logic [15:0]       num_out_q;
    logic [15:0]       out_cnt_q;
    logic [4:0]        shift_q;
    logic              relu_q;
    logic [ACC_BW-1:0] acc_q;
    logic              done_q;
    logic              ovf_q;

    logic [15:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              xfer;
    logic              last_tile;
    logic              push;
    logic              pop;
    logic [ACC_BW-1:0] psum_ext;

    logic signed [PpW-1:0] sum_w;
    logic signed [PpW-1:0] half_w;
    logic signed [PpW-1:0] round_w;
    logic signed [PpW-1:0] shift_w;
    logic signed [PpW-1:0] relu_w;
    logic [15:0]           res_w;
    logic                  sat_w;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign oPsumReady = (state_q == StAcc) && !fifo_full;
    assign xfer       = iPsumValid && oPsumReady;
    assign last_tile  = (tile_cnt_q == tiles_q - 8'd1);
    assign push       = xfer && last_tile;
    assign pop        = !fifo_empty && iReady;
    assign psum_ext   = {{(ACC_BW - IN_BW){iPsum[IN_BW-1]}}, iPsum};

    // Requantization of acc + the final partial sum.
    assign sum_w   = {acc_q[ACC_BW-1], acc_q} + {psum_ext[ACC_BW-1], psum_ext};
    assign half_w  = (shift_q != 5'd0) ? (PpW'(1) << (shift_q - 5'd1)) : '0;
    assign round_w = sum_w + half_w;
    assign shift_w = round_w >>> shift_q;
    assign relu_w  = (relu_q && shift_w[PpW-1]) ? '0 : shift_w;

    always_comb begin
        res_w = relu_w[15:0];
        sat_w = 1'b0;
        // Fits in 16 bits only if every bit above bit 15 equals the sign.
        if (!((relu_w[PpW-1:15] == '0) || (relu_w[PpW-1:15] == '1))) begin
            sat_w = 1'b1;
            res_w = relu_w[PpW-1] ? 16'h8000 : 16'h7fff;
        end
    end

    assign oValid    = !fifo_empty;
    assign oData     = fifo_empty ? 16'd0 : mem_q[rd_ptr_q];
    assign oBusy     = (state_q != StIdle);
    assign oDone     = done_q;
    assign oOverflow = ovf_q;

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q    <= StIdle;
            tiles_q    <= 8'd0;
            tile_cnt_q <= 8'd0;
            num_out_q  <= 16'd0;
            out_cnt_q  <= 16'd0;
            shift_q    <= 5'd0;
            relu_q     <= 1'b0;
            acc_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (iStart) begin
                        tiles_q    <= (iTiles == 8'd0) ? 8'd1 : iTiles;
                        num_out_q  <= iNumOut;
                        shift_q    <= iShift;
                        relu_q     <= iReluEn;
                        acc_q      <= '0;
                        tile_cnt_q <= 8'd0;
                        out_cnt_q  <= 16'd0;
                        ovf_q      <= 1'b0;
                        state_q    <= (iNumOut == 16'd0) ? StDone : StAcc;
                    end
                end
                StAcc: begin
                    if (xfer) begin
                        if (last_tile) begin
                            acc_q      <= '0;
                            tile_cnt_q <= 8'd0;
                            out_cnt_q  <= out_cnt_q + 16'd1;
                            if (sat_w) begin
                                ovf_q <= 1'b1;
                            end
                            if (out_cnt_q == num_out_q - 16'd1) begin
                                state_q <= StDone;
                            end
                        end else begin
                            acc_q      <= acc_q + psum_ext;
                            tile_cnt_q <= tile_cnt_q + 8'd1;
                        end
                    end
                end
                StDone: begin
                    // Done only once every queued result has been taken.
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: oData is masked while the FIFO is empty.
    always_ff @(posedge iCLK) begin
        if (iRSTn && push) begin
            mem_q[wr_ptr_q] <= res_w;
        end
    end

endmodule
